// File: rtl/counter_button_ctrl.sv
// rtl/counter_button_ctrl.sv - button press sequencer producing step/clr commands for the LED step counter
module counter_button_ctrl #(
    parameter int LONG_CYCLES  = 50_000_000,
    parameter int CLEAR_CYCLES = 200_000_000,
    parameter int AUTO_PERIOD  = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic step,
    output logic clr,
    output logic auto_mode,
    output logic busy
);

    localparam int CW = $clog2(CLEAR_CYCLES + 1);
    localparam int TW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [CW-1:0] LONG_C    = CW'(LONG_CYCLES);
    localparam logic [CW-1:0] CLEAR_C   = CW'(CLEAR_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(AUTO_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, PRESSED, HELD, WAIT_REL} state_t;

    state_t        state, state_n;
    logic          btn_q;
    logic [CW-1:0] press_cnt, press_cnt_n, cnt_inc;
    logic [TW-1:0] tick_cnt, tick_n;
    logic          auto_n, clr_n, step_n, mstep, wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            btn_q     <= 1'b1;
            press_cnt <= '0;
            tick_cnt  <= '0;
            auto_mode <= 1'b0;
            step      <= 1'b0;
            clr       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            btn_q     <= btn;
            press_cnt <= press_cnt_n;
            tick_cnt  <= tick_n;
            auto_mode <= auto_n;
            step      <= step_n;
            clr       <= clr_n;
            busy      <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n     = state;
        press_cnt_n = press_cnt;
        auto_n      = auto_mode;
        clr_n       = 1'b0;
        mstep       = 1'b0;
        // Saturating count so a forgotten held button never wraps back into a long press
        cnt_inc     = (press_cnt == CLEAR_C) ? press_cnt : press_cnt + CW'(1);

        case (state)
            IDLE: begin
                if (btn && !btn_q) begin
                    state_n     = PRESSED;
                    press_cnt_n = CW'(1);
                end
            end
            PRESSED: begin
                if (!btn) begin
                    state_n = IDLE;
                    mstep   = !auto_mode;
                end else begin
                    press_cnt_n = cnt_inc;
                    if (cnt_inc == LONG_C) begin
                        auto_n  = !auto_mode;
                        state_n = HELD;
                    end
                end
            end
            HELD: begin
                if (!btn) begin
                    state_n = IDLE;
                end else begin
                    press_cnt_n = cnt_inc;
                    if (cnt_inc == CLEAR_C) begin
                        clr_n   = 1'b1;
                        auto_n  = 1'b0;
                        state_n = WAIT_REL;
                    end
                end
            end
            WAIT_REL: begin
                if (!btn) begin
                    state_n = IDLE;
                end else begin
                    press_cnt_n = cnt_inc;
                end
            end
            default: state_n = IDLE;
        endcase

        // Auto tick: wraps only while auto-run is already active; clr wins over a coincident wrap
        wrap = auto_mode && (tick_cnt == TICK_LAST);
        if (!auto_n || clr_n || !auto_mode || wrap) begin
            tick_n = '0;
        end else begin
            tick_n = tick_cnt + TW'(1);
        end
        step_n = mstep || (wrap && !clr_n);
    end

endmodule

// File: tb/tb_counter_button_ctrl.sv
// tb/tb_counter_button_ctrl.sv - self-checking bench for counter_button_ctrl
module tb_counter_button_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    always #5 clk = ~clk;

    logic step0, clr0, auto0, busy0;
    logic step1, clr1, auto1, busy1;

    counter_button_ctrl #(.LONG_CYCLES(8), .CLEAR_CYCLES(20), .AUTO_PERIOD(5)) u0 (
        .clk(clk), .rst(rst), .btn(btn),
        .step(step0), .clr(clr0), .auto_mode(auto0), .busy(busy0)
    );

    counter_button_ctrl #(.LONG_CYCLES(4), .CLEAR_CYCLES(10), .AUTO_PERIOD(3)) u1 (
        .clk(clk), .rst(rst), .btn(btn),
        .step(step1), .clr(clr1), .auto_mode(auto1), .busy(busy1)
    );

    int lp[2] = '{8, 4};
    int cp[2] = '{20, 10};
    int pp[2] = '{5, 3};

    // Reference: press length in samples, cycles since auto-run started
    bit m_prev[2], m_in[2], m_auto[2], e_step[2], e_clr[2];
    int m_hold[2], m_age[2];

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        bit         r;
        bit         b;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] outs(int k);
        return (k == 0) ? {step0, clr0, auto0, busy0} : {step1, clr1, auto1, busy1};
    endfunction

    task automatic model_step(int k, bit r, bit b);
        bit old_auto;
        if (r) begin
            m_prev[k] = 1'b1; m_in[k] = 1'b0; m_auto[k] = 1'b0;
            m_hold[k] = 0;    m_age[k] = 0;
            e_step[k] = 1'b0; e_clr[k] = 1'b0;
        end else begin
            old_auto  = m_auto[k];
            e_step[k] = 1'b0;
            e_clr[k]  = 1'b0;
            if (!m_in[k]) begin
                if (b && !m_prev[k]) begin
                    m_in[k]   = 1'b1;
                    m_hold[k] = 1;
                end
            end else if (b) begin
                m_hold[k]++;
                if (m_hold[k] == lp[k]) m_auto[k] = !m_auto[k];
                if (m_hold[k] == cp[k]) begin
                    e_clr[k]  = 1'b1;
                    m_auto[k] = 1'b0;
                end
            end else begin
                if (m_hold[k] < lp[k] && !old_auto) e_step[k] = 1'b1;
                m_in[k] = 1'b0;
            end
            if (old_auto) begin
                m_age[k]++;
                if ((m_age[k] % pp[k]) == 0 && !e_clr[k]) e_step[k] = 1'b1;
            end
            if (m_auto[k] && !old_auto) m_age[k] = 0;
            m_prev[k] = b;
        end
    endtask

    task automatic cyc(bit r, bit b);
        rst = r;
        btn = b;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            model_step(k, r, b);
            chk($sformatf("model i%0d sdab", k), outs(k), {e_step[k], e_clr[k], m_auto[k], m_in[k]});
        end
        @(negedge clk);
    endtask

    initial begin
        int since;
        int cnt0, cnt1;
        logic any;

        // Reset, then a 3-sample press: step one cycle after release, busy for 3 cycles
        tbl[0] = '{1'b1, 1'b0, 4'b0000};
        tbl[1] = '{1'b0, 1'b0, 4'b0000};
        tbl[2] = '{1'b0, 1'b1, 4'b0001};
        tbl[3] = '{1'b0, 1'b1, 4'b0001};
        tbl[4] = '{1'b0, 1'b1, 4'b0001};
        tbl[5] = '{1'b0, 1'b0, 4'b1000};
        tbl[6] = '{1'b0, 1'b0, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].r, tbl[i].b);
            chk($sformatf("tbl[%0d] sdab", i), outs(0), tbl[i].exp);
        end

        // Long press: auto rises on sample 8, steps every 5 cycles thereafter
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b0, 1'b1);
            if (i == 7) chk("s2 auto before", auto0, 0);
            if (i == 8) chk("s2 auto rise", auto0, 1);
        end
        since = 2;
        cyc(1'b0, 1'b0);
        since++;
        chk("s2 no step at release", step0, 0);
        for (int i = 0; i < 13; i++) begin
            cyc(1'b0, 1'b0);
            since++;
            chk("s2 cadence", step0, (since % 5) == 0);
        end

        // Short press in auto mode is ignored, cadence unchanged
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, i < 2);
            since++;
            chk("s3 cadence", step0, (since % 5) == 0);
        end

        // 25-sample press from auto: off at 8, clr at 20, nothing else
        for (int i = 1; i <= 25; i++) begin
            cyc(1'b0, 1'b1);
            since++;
            if (i <= 8) chk("s4 cadence", step0, (since % 5) == 0);
            else        chk("s4 no step", step0, 0);
            if (i == 8) chk("s4 auto off", auto0, 0);
            chk("s4 clr", clr0, i == 20);
        end
        chk("s4 busy held", busy0, 1);
        cyc(1'b0, 1'b0);
        chk("s4 busy fall", busy0, 0);

        // Back to auto, then a 20-sample press ending in clr
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("s5 auto on", auto0, 1);
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 1'b1);
            if (i == 20) chk("s5 clr/step", {clr0, step0}, 2'b10);
        end
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0);
            chk("s5 quiet", {step0, auto0}, 2'b00);
        end

        // Reset while held: ignored until release
        cyc(1'b1, 1'b1);
        chk("s6 rst i0", outs(0), 4'b0000);
        chk("s6 rst i1", outs(1), 4'b0000);
        any = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b0, 1'b1);
            any = any | step0 | clr0 | auto0 | step1 | clr1 | auto1;
        end
        chk("s6 held ignored", any, 0);
        cyc(1'b0, 1'b0);
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, i < 3);
            cnt0 += step0;
            cnt1 += step1;
        end
        chk("s6 one step i0", cnt0, 1);
        chk("s6 one step i1", cnt1, 1);

        // Instance 1: clr lands on a tick wrap (rise at 4, wraps at 7 and 10, clr at 10)
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b0, 1'b1);
            if (i == 4)  chk("s7 auto rise", auto1, 1);
            if (i == 7)  chk("s7 tick step", step1, 1);
            if (i == 10) chk("s7 clr beats step", {clr1, step1}, 2'b10);
        end
        cyc(1'b0, 1'b0);
        chk("s7 auto cleared", auto1, 0);

        // Random press lengths against the reference
        for (int seg = 0; seg < 250; seg++) begin
            int lo, hi, cls;
            if ($urandom_range(0, 40) == 0) cyc(1'b1, 1'($urandom_range(0, 1)));
            lo  = $urandom_range(1, 6);
            cls = $urandom_range(0, 2);
            hi  = (cls == 0) ? $urandom_range(1, 3) : (cls == 1) ? $urandom_range(4, 12) : $urandom_range(15, 30);
            for (int i = 0; i < lo; i++) cyc(1'b0, 1'b0);
            for (int i = 0; i < hi; i++) cyc(1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
